// File: rtl/tm1638_led_tx.sv
// Write-only TM1638 LED driver: serialises an 8-bit LED pattern over STB/CLK/DIO.
// A full three-packet frame is sent after reset and whenever the pattern changes.
module tm1638_led_tx #(
    parameter int unsigned CLK_DIV = 25,
    parameter logic [2:0]  BRIGHT  = 3'd7
) (
    input  logic       clki,
    input  logic       rs,
    input  logic [7:0] led,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy,
    output logic       frame_done
);
    localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam int unsigned   SW      = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB_LO,
        S_SHIFT,
        S_STB_HI,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pkt_q, pkt_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [7:0]    snap_q, snap_d;
    logic          pending_q, pending_d;
    logic          stb_q, stb_d;
    logic          clk_q, clk_d;
    logic          dio_q, dio_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick;
    logic [SW-1:0] sh_nxt;
    logic [SW-1:0] sh_last;
    logic [SW-1:0] bsel;
    logic [7:0]    nxt_byte;

    // Byte idx of packet pkt; P2 data bytes alternate blank segments / LED bit.
    function automatic logic [7:0] pkt_byte(input logic [1:0] pkt, input logic [4:0] idx,
                                            input logic [7:0] pat);
        logic [2:0] k;
        k = 3'(idx[4:1] - 4'd1);
        case (pkt)
            2'd0:    pkt_byte = 8'h40;
            2'd1: begin
                if (idx == 5'd0)      pkt_byte = 8'hC0;
                else if (idx[0])      pkt_byte = 8'h00;
                else                  pkt_byte = {7'b0, pat[k]};
            end
            default: pkt_byte = {5'b10001, BRIGHT};
        endcase
    endfunction

    assign tick     = (cnt_q == CNT_MAX);
    assign sh_nxt   = sh_q + 9'd1;
    assign sh_last  = (pkt_q == 2'd1) ? 9'd271 : 9'd15;
    assign bsel     = (state_q == S_SHIFT) ? sh_nxt : '0;
    assign nxt_byte = pkt_byte(pkt_q, bsel[8:4], snap_q);

    // Next-state and registered-output logic; everything moves only on tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        pkt_d     = pkt_q;
        sh_d      = sh_q;
        snap_d    = snap_q;
        pending_d = pending_q | (led != snap_q);
        stb_d     = stb_q;
        clk_d     = clk_q;
        dio_d     = dio_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        snap_d    = led;
                        pending_d = 1'b0;
                        busy_d    = 1'b1;
                        pkt_d     = 2'd0;
                        stb_d     = 1'b0;
                        state_d   = S_STB_LO;
                    end
                end
                S_STB_LO: begin
                    sh_d    = '0;
                    clk_d   = 1'b0;
                    dio_d   = nxt_byte[0];
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (sh_q == sh_last) begin
                        stb_d   = 1'b1;
                        clk_d   = 1'b1;
                        dio_d   = 1'b1;
                        state_d = S_STB_HI;
                    end else begin
                        sh_d = sh_nxt;
                        if (sh_nxt[0]) begin
                            clk_d = 1'b1;
                        end else begin
                            clk_d = 1'b0;
                            dio_d = nxt_byte[sh_nxt[3:1]];
                        end
                    end
                end
                S_STB_HI: state_d = S_GAP;
                S_GAP: begin
                    if (pkt_q == 2'd2) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pkt_d   = pkt_q + 2'd1;
                        stb_d   = 1'b0;
                        state_d = S_STB_LO;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clki) begin
        if (rs) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pkt_q     <= 2'd0;
            sh_q      <= '0;
            snap_q    <= 8'h00;
            pending_q <= 1'b1;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            dio_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            sh_q      <= sh_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            stb_q     <= stb_d;
            clk_q     <= clk_d;
            dio_q     <= dio_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tm_stb     = stb_q;
    assign tm_clk     = clk_q;
    assign tm_dio     = dio_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_tm1638_led_tx.sv
// Scoreboard bench for tm1638_led_tx: expected bytes are queued by the stimulus,
// a serial-line decoder pops and compares them as the DUTs shift them out.
module tb_tm1638_led_tx;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned FRAME_CYC = 313 * CLK_DIV;

    logic       clki = 1'b0;
    logic       rs   = 1'b1;
    logic [7:0] led  = 8'h00;
    logic [1:0] stb, sclk, dio, busy, done;

    tm1638_led_tx #(.CLK_DIV(CLK_DIV), .BRIGHT(3'd7)) u_dut0 (
        .clki(clki), .rs(rs), .led(led), .tm_stb(stb[0]), .tm_clk(sclk[0]),
        .tm_dio(dio[0]), .busy(busy[0]), .frame_done(done[0]));
    tm1638_led_tx #(.CLK_DIV(CLK_DIV), .BRIGHT(3'd2)) u_dut1 (
        .clki(clki), .rs(rs), .led(led), .tm_stb(stb[1]), .tm_clk(sclk[1]),
        .tm_dio(dio[1]), .busy(busy[1]), .frame_done(done[1]));

    always #5 clki = ~clki;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected frame: 0x40 | 0xC0, 16 data bytes | 0x88|BRIGHT.
    task automatic push_frame(input logic [7:0] pat);
        logic [7:0] b;
        exp_q0.push_back(8'h40);
        exp_q1.push_back(8'h40);
        exp_q0.push_back(8'hC0);
        exp_q1.push_back(8'hC0);
        for (int j = 0; j < 16; j++) begin
            b = (j % 2 == 1) ? {7'b0, pat[j/2]} : 8'h00;
            exp_q0.push_back(b);
            exp_q1.push_back(b);
        end
        exp_q0.push_back(8'h8F);
        exp_q1.push_back(8'h8A);
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 4 * FRAME_CYC) begin
            @(posedge clki);
            k++;
        end
        #1;
        chk("frame_done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_busy();
        int k = 0;
        while (busy[0] !== 1'b1 && k < 4 * FRAME_CYC) begin
            @(posedge clki);
            k++;
        end
        #1;
        chk("busy_rise_seen", 32'(busy[0]), 32'd1);
    endtask

    // Serial decoder / scoreboard monitor, sampled on the falling edge.
    initial begin
        logic [1:0] pstb, pclk, pdio;
        logic [7:0] shr[2];
        logic [7:0] e;
        int         nb[2], nby[2], wi[2];
        logic       bad[2];
        logic       pbusy, pdone, armed;
        int         blen, gap;
        pstb = '1; pclk = '1; pdio = '1;
        pbusy = 1'b0; pdone = 1'b0; armed = 1'b0; blen = 0; gap = 0;
        for (int d = 0; d < 2; d++) begin
            shr[d] = 8'h00; nb[d] = 0; nby[d] = 0; wi[d] = 0; bad[d] = 1'b0;
        end
        forever begin
            @(negedge clki);
            if (rs) begin
                pstb = '1; pclk = '1; pdio = '1;
                pbusy = 1'b0; pdone = 1'b0; armed = 1'b0; blen = 0; gap = 0;
                for (int d = 0; d < 2; d++) begin
                    nb[d] = 0; nby[d] = 0; wi[d] = 0; bad[d] = 1'b0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (!stb[d] && sclk[d] && pclk[d] && dio[d] != pdio[d]) bad[d] = 1'b1;
                    if (!stb[d] && sclk[d] && !pclk[d]) begin
                        shr[d] = {dio[d], shr[d][7:1]};
                        nb[d]++;
                        if (nb[d] == 8) begin
                            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_byte dut%0d actual=%0h required=none", d, shr[d]);
                            end else begin
                                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                chk((d == 0) ? "byte_dut0" : "byte_dut1", 32'(shr[d]), 32'(e));
                            end
                            chk("dio_stable_while_clk_high", 32'(bad[d]), 32'd0);
                            nb[d] = 0;
                            nby[d]++;
                            bad[d] = 1'b0;
                        end
                    end
                    if (stb[d] && !pstb[d]) begin
                        chk("stb_window_bits", 32'(nby[d] * 8 + nb[d]), (wi[d] == 1) ? 32'd136 : 32'd8);
                        wi[d] = (wi[d] + 1) % 3;
                        nby[d] = 0;
                        nb[d] = 0;
                    end
                end
                pstb = stb; pclk = sclk; pdio = dio;
                if (busy[0]) blen++;
                if (armed) gap++;
                if (busy[0] && !pbusy) begin
                    if (armed && gap < 50) chk("idle_gap_cycles", 32'(gap), 32'(CLK_DIV));
                    armed = 1'b0;
                end
                if (done[0]) begin
                    chk("busy_len", 32'(blen), 32'(FRAME_CYC));
                    chk("busy_low_at_done", 32'(busy[0]), 32'd0);
                    chk("done_width", 32'(pdone), 32'd0);
                    done_cnt++;
                    blen = 0;
                    gap = 0;
                    armed = 1'b1;
                end
                pbusy = busy[0];
                pdone = done[0];
            end
        end
    end

    initial begin
        rs = 1'b1;
        led = 8'h00;
        repeat (4) @(posedge clki);
        #1;
        chk("rst_stb", 32'(stb[0]), 32'd1);
        chk("rst_clk", 32'(sclk[0]), 32'd1);
        chk("rst_dio", 32'(dio[0]), 32'd1);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);

        // One frame after reset with led held at zero, then idle.
        push_frame(8'h00);
        rs = 1'b0;
        wait_done(1);
        repeat (200) @(posedge clki);
        #1;
        chk("idle_no_extra_frame", 32'(done_cnt), 32'd1);
        chk("idle_lines", {29'b0, stb[0], sclk[0], dio[0]}, 32'd7);
        chk("idle_busy", 32'(busy[0]), 32'd0);

        // Pattern 0x05 from idle.
        led = 8'h05;
        push_frame(8'h05);
        wait_done(2);
        repeat (100) @(posedge clki);

        // Change mid-P2: current frame keeps 0x01, follow-up carries 0x02.
        #1 led = 8'h01;
        push_frame(8'h01);
        wait_busy();
        repeat (300) @(posedge clki);
        #1 led = 8'h02;
        push_frame(8'h02);
        wait_done(4);
        repeat (100) @(posedge clki);

        // Reset pulse mid-P2 aborts; a fresh frame follows without frame_done for the aborted one.
        #1 led = 8'h03;
        push_frame(8'h03);
        wait_busy();
        repeat (300) @(posedge clki);
        #1 rs = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        push_frame(8'h03);
        @(posedge clki);
        #1 rs = 1'b0;
        chk("abort_stb", 32'(stb[0]), 32'd1);
        chk("abort_clk", 32'(sclk[0]), 32'd1);
        chk("abort_dio", 32'(dio[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd4);
        wait_done(5);
        repeat (100) @(posedge clki);

        // Toggle led for 10 cycles mid-frame: exactly one follow-up frame with the final value.
        #1 led = 8'h10;
        push_frame(8'h10);
        wait_busy();
        repeat (100) @(posedge clki);
        for (int i = 0; i < 10; i++) begin
            @(posedge clki);
            #1 led = (i % 2 == 0) ? 8'h55 : 8'hAA;
        end
        push_frame(8'hAA);
        wait_done(7);
        repeat (700) @(posedge clki);
        #1;
        chk("final_done_count", 32'(done_cnt), 32'd7);
        chk("final_q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("final_q1_empty", 32'(exp_q1.size()), 32'd0);
        chk("final_idle_lines", {29'b0, stb[0], sclk[0], dio[0]}, 32'd7);
        chk("final_busy", 32'(busy[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
